// File: rtl/shift_register_out.sv
// Serial shifter: streams 1..32 bits of a parallel word on sclk/sdo, MSB- or LSB-first.
// Optional active-low chip select on cs_n when SHIFT_REGISTER_OUT_CS_EN is defined.
module shift_register_out #(
    parameter int CLK_DIV = 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        lsb_first,
    input  logic [4:0]  bit_count,
    input  logic [31:0] data_in,
    output logic        sclk,
    output logic        sdo,
    output logic        busy,
    output logic        done
`ifdef SHIFT_REGISTER_OUT_CS_EN
    ,
    output logic        cs_n
`endif
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [5:0]  bits_left;
    logic [31:0] shift_reg;
    logic        lsb_mode;

    logic [5:0]  start_len;
    logic [31:0] msb_aligned;
    logic        phase_end;

    assign start_len   = (bit_count == 5'd0) ? 6'd32 : {1'b0, bit_count};
    // MSB-first words are left-aligned so the current bit is always shift_reg[31].
    assign msb_aligned = data_in << (6'd32 - start_len);
    assign phase_end   = (phase_cnt == PHASE_LAST);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= 8'd0;
            bits_left <= 6'd0;
            shift_reg <= 32'd0;
            lsb_mode  <= 1'b0;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SHIFT_REGISTER_OUT_CS_EN
            cs_n      <= 1'b1;
`endif
        end else if (abort && (state == LOW || state == HIGH)) begin
            state     <= IDLE;
            phase_cnt <= 8'd0;
            bits_left <= 6'd0;
            shift_reg <= 32'd0;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SHIFT_REGISTER_OUT_CS_EN
            cs_n      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state     <= LOW;
                        phase_cnt <= 8'd0;
                        bits_left <= start_len;
                        lsb_mode  <= lsb_first;
                        shift_reg <= lsb_first ? data_in : msb_aligned;
                        sdo       <= lsb_first ? data_in[0] : msb_aligned[31];
                        sclk      <= 1'b0;
                        busy      <= 1'b1;
`ifdef SHIFT_REGISTER_OUT_CS_EN
                        cs_n      <= 1'b0;
`endif
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state     <= HIGH;
                        phase_cnt <= 8'd0;
                        sclk      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase_cnt <= 8'd0;
                        sclk      <= 1'b0;
                        bits_left <= bits_left - 6'd1;
                        if (bits_left == 6'd1) begin
                            state     <= DONE;
                            shift_reg <= 32'd0;
                            sdo       <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`ifdef SHIFT_REGISTER_OUT_CS_EN
                            cs_n      <= 1'b1;
`endif
                        end else begin
                            state     <= LOW;
                            shift_reg <= lsb_mode ? (shift_reg >> 1) : (shift_reg << 1);
                            sdo       <= lsb_mode ? shift_reg[1] : shift_reg[30];
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_out.sv
// Scoreboard bench for shift_register_out: stimulus queues expected streams, a monitor
// reconstructs each stream from sclk/sdo and compares when busy falls.
module tb_shift_register_out;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lsb_first = 1'b0;
    logic [4:0]  bit_count = 5'd0;
    logic [31:0] data_in = 32'd0;
    logic        sclk, sdo, busy, done;
`ifdef SHIFT_REGISTER_OUT_CS_EN
    logic        cs_n;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          busy_len;
        bit          aborted;
    } exp_t;

    exp_t exp_q[$];

    shift_register_out #(.CLK_DIV(DIV)) u_dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .lsb_first (lsb_first),
        .bit_count (bit_count),
        .data_in   (data_in),
        .sclk      (sclk),
        .sdo       (sdo),
        .busy      (busy),
        .done      (done)
`ifdef SHIFT_REGISTER_OUT_CS_EN
        ,
        .cs_n      (cs_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Bit k of the result is the k-th bit on the wire.
    function automatic logic [31:0] stream_word(input logic [31:0] d, input int n, input bit lsb, input int cnt);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < cnt; k++)
            w[k] = lsb ? d[k] : d[n-1-k];
        return w;
    endfunction

    // sclk rises DIV cycles into every 2*DIV-cycle bit period.
    function automatic int edges_within(input int len);
        int c;
        c = 0;
        for (int t = 0; t < len; t++)
            if (t % (2*DIV) == DIV) c++;
        return c;
    endfunction

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 4000 && busy; i++) wait_clk();
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected 0", i);
        end
        wait_clk();
        wait_clk();
    endtask

    task automatic launch(input logic [31:0] d, input logic [4:0] bc, input bit lsb,
                          input int abort_after, input int restart_at);
        int   n;
        exp_t e;
        n = (bc == 5'd0) ? 32 : int'(bc);
        if (abort_after >= 0) begin
            e.busy_len = abort_after + 1;
            e.nbits    = edges_within(e.busy_len);
            e.aborted  = 1'b1;
        end else begin
            e.busy_len = 2 * DIV * n;
            e.nbits    = n;
            e.aborted  = 1'b0;
        end
        e.word = stream_word(d, n, lsb, e.nbits);
        exp_q.push_back(e);
        data_in = d; bit_count = bc; lsb_first = lsb; start = 1'b1;
        wait_clk();
        start = 1'b0;
        check("start_accepted_busy", busy, 1);
        data_in = $urandom; bit_count = 5'($urandom); lsb_first = 1'($urandom);
        if (abort_after >= 0) begin
            repeat (abort_after) wait_clk();
            abort = 1'b1;
            wait_clk();
            abort = 1'b0;
        end else if (restart_at >= 0) begin
            repeat (restart_at) wait_clk();
            data_in = ~d; bit_count = 5'd3; lsb_first = ~lsb; start = 1'b1;
            wait_clk();
            start = 1'b0;
        end
        wait_done();
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        int          busy_cycles, cnt, cs_low;
        logic [31:0] word;
        logic        busy_prev, sclk_prev;
        exp_t        e;
        busy_cycles = 0; cnt = 0; cs_low = 0; word = 32'd0; busy_prev = 1'b0; sclk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cycles = 0; cnt = 0; cs_low = 0; word = 32'd0;
                busy_prev = 1'b0; sclk_prev = 1'b0;
                continue;
            end
            if (busy) begin
                busy_cycles++;
                if (sclk && !sclk_prev && cnt < 32) begin
                    word[cnt] = sdo;
                    cnt++;
                end
            end
`ifdef SHIFT_REGISTER_OUT_CS_EN
            if (!cs_n) cs_low++;
`endif
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_transfer: got %0d busy cycles, expected none", busy_cycles);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_len", busy_cycles, e.busy_len);
                    check("bit_count_seen", cnt, e.nbits);
                    check("bit_stream", word, e.word);
                    check("done_pulse", done, !e.aborted);
                    check("sclk_after", sclk, 0);
                    check("sdo_after", sdo, 0);
`ifdef SHIFT_REGISTER_OUT_CS_EN
                    check("cs_low_cycles", cs_low, e.busy_len);
                    check("cs_n_after", cs_n, 1);
`endif
                end
                busy_cycles = 0; cnt = 0; cs_low = 0; word = 32'd0;
            end else if (done) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done=1, expected 0");
            end
            busy_prev = busy;
            sclk_prev = sclk;
        end
    end

    initial begin
        int          n, ab, i;
        logic [31:0] d;
        logic [4:0]  bc;
        bit          lsb;

        #12;
        check("reset_sclk", sclk, 0);
        check("reset_sdo", sdo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
`ifdef SHIFT_REGISTER_OUT_CS_EN
        check("reset_cs_n", cs_n, 1);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        launch(32'hA5A5_0F0F, 5'd0, 1'b0, -1, -1);
        launch(32'h0000_00B4, 5'd8, 1'b1, -1, -1);
        launch(32'hDEAD_BEEF, 5'd12, 1'b0, -1, DIV * 6 + 1);
        launch(32'h1234_ABCD, 5'd16, 1'b0, 2 * DIV * 4 + 1, -1);
        launch(32'h8001_7FFE, 5'd16, 1'b1, -1, -1);
        launch(32'h0000_0005, 5'd3, 1'b1, 2 * DIV * 3 - 1, -1);
        launch(32'hFFFF_FFFF, 5'd1, 1'b0, -1, -1);

        start = 1'b1; abort = 1'b1; data_in = 32'hFFFF_0000; bit_count = 5'd4;
        wait_clk();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        wait_clk();

        data_in = 32'h5555_AAAA; bit_count = 5'd16; lsb_first = 1'b0; start = 1'b1;
        wait_clk();
        start = 1'b0;
        for (i = 0; i < 100 && !sclk; i++) wait_clk();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_sclk", sclk, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_sdo", sdo, 0);
`ifdef SHIFT_REGISTER_OUT_CS_EN
        check("async_reset_cs_n", cs_n, 1);
`endif
        repeat (2) wait_clk();
        reset = 1'b0;
        launch(32'hC3C3_3C3C, 5'd10, 1'b1, -1, -1);

        for (int t = 0; t < 24; t++) begin
            d   = $urandom;
            bc  = 5'($urandom_range(0, 31));
            lsb = 1'($urandom_range(0, 1));
            n   = (bc == 5'd0) ? 32 : int'(bc);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * DIV * n - 1)) : -1;
            launch(d, bc, lsb, ab, -1);
        end

        repeat (4) wait_clk();
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
